// File: rtl/addsub_pkg.sv
// Shared types and constants for the serial add/subtract unit.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_serial_if.sv
// Start/done request bus of the serial add/subtract unit.
interface addsub_serial_if #(
   parameter int WIDTH = 8
) ();
   logic             start;
   logic             mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             overflow;
   logic             zero;

   modport master (
      output start, mode, a, b,
      input  busy, done, sum, carry, overflow, zero
   );

   modport slave (
      input  start, mode, a, b,
      output busy, done, sum, carry, overflow, zero
   );
endinterface

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple slice; B is inverted when subtracting.
module addsub_digit
   import addsub_pkg::*;
#(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] a_d,
   input  logic [DIGIT-1:0] b_d,
   input  logic             cin,
   input  logic             mode,
   output logic [DIGIT-1:0] s_d,
   output logic             cout,
   output logic             cin_msb
);

   logic [DIGIT-1:0] b_eff;
   logic             carry_chain;

   for (genvar gi = 0; gi < DIGIT; gi++) begin : g_beff
      assign b_eff[gi] = b_d[gi] ^ (mode == MODE_SUB);
   end

   // cin_msb ends up as the carry entering the top bit of the slice
   always_comb begin
      carry_chain = cin;
      cin_msb     = cin;
      s_d         = '0;
      for (int i = 0; i < DIGIT; i++) begin
         cin_msb     = carry_chain;
         s_d[i]      = a_d[i] ^ b_eff[i] ^ carry_chain;
         carry_chain = (a_d[i] & b_eff[i]) | (a_d[i] & carry_chain) | (b_eff[i] & carry_chain);
      end
      cout = carry_chain;
   end

endmodule

// File: rtl/addsub_serial.sv
// Sequential add/subtract, DIGIT bits per clock, LSB digit first.
// Define ADDSUB_SAT_EN to clamp overflowing results to signed max/min.
module addsub_serial
   import addsub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input logic            clk,
   input logic            rst_n,
   addsub_serial_if.slave bus
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   state_t           state, state_next;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_next, sum_fin;
   logic             mode_r, cy_r;
   logic [WIDTH-1:0] sum_r;
   logic             carry_r, ovf_r, zero_r;
   logic [DIGIT-1:0] s_d;
   logic             cout, cin_msb, ovf_now;
   logic             busy, done, accept, step, last;

   addsub_digit #(.DIGIT(DIGIT)) u_digit (
      .a_d     (a_sh[DIGIT-1:0]),
      .b_d     (b_sh[DIGIT-1:0]),
      .cin     (cy_r),
      .mode    (mode_r),
      .s_d     (s_d),
      .cout    (cout),
      .cin_msb (cin_msb)
   );

   assign last    = (cnt == CW'(N - 1));
   assign ovf_now = cin_msb ^ cout;
   // New digit enters at the top so the final digit leaves the word LSB-aligned
   assign res_next = (res_sh >> DIGIT) | (WIDTH'(s_d) << (WIDTH - DIGIT));

`ifdef ADDSUB_SAT_EN
   always_comb begin
      sum_fin = res_next;
      if (ovf_now)
         sum_fin = res_next[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
   end
`else
   assign sum_fin = res_next;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      accept     = 1'b0;
      step       = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               accept     = 1'b1;
               state_next = RUN;
            end
         end
         RUN: begin
            busy = 1'b1;
            step = 1'b1;
            if (last) state_next = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (bus.start) begin
               accept     = 1'b1;
               state_next = RUN;
            end else begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         a_sh    <= '0;
         b_sh    <= '0;
         res_sh  <= '0;
         mode_r  <= MODE_ADD;
         cy_r    <= 1'b0;
         sum_r   <= '0;
         carry_r <= 1'b0;
         ovf_r   <= 1'b0;
         zero_r  <= 1'b0;
      end else if (accept) begin
         a_sh   <= bus.a;
         b_sh   <= bus.b;
         mode_r <= bus.mode;
         cy_r   <= bus.mode;
         cnt    <= '0;
      end else if (step) begin
         a_sh   <= a_sh >> DIGIT;
         b_sh   <= b_sh >> DIGIT;
         res_sh <= res_next;
         cy_r   <= cout;
         cnt    <= cnt + 1'b1;
         if (last) begin
            sum_r   <= sum_fin;
            carry_r <= cout;
            ovf_r   <= ovf_now;
            zero_r  <= (sum_fin == '0);
         end
      end
   end

   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.sum      = sum_r;
   assign bus.carry    = carry_r;
   assign bus.overflow = ovf_r;
   assign bus.zero     = zero_r;

endmodule

// File: tb/tb_addsub_serial.sv
// Directed bench for addsub_serial: one 8-bit/1-bit main instance plus digit-width variants.
module tb_addsub_serial;
   import addsub_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   addsub_serial_if #(.WIDTH(8))  m   ();
   addsub_serial_if #(.WIDTH(8))  v2  ();
   addsub_serial_if #(.WIDTH(8))  v4  ();
   addsub_serial_if #(.WIDTH(8))  v8  ();
   addsub_serial_if #(.WIDTH(16)) v16 ();

   logic        v_start = 1'b0;
   logic        v_mode  = 1'b0;
   logic [15:0] v_a     = '0;
   logic [15:0] v_b     = '0;

   assign v2.start  = v_start; assign v2.mode  = v_mode; assign v2.a  = v_a[7:0]; assign v2.b  = v_b[7:0];
   assign v4.start  = v_start; assign v4.mode  = v_mode; assign v4.a  = v_a[7:0]; assign v4.b  = v_b[7:0];
   assign v8.start  = v_start; assign v8.mode  = v_mode; assign v8.a  = v_a[7:0]; assign v8.b  = v_b[7:0];
   assign v16.start = v_start; assign v16.mode = v_mode; assign v16.a = v_a;      assign v16.b = v_b;

   addsub_serial #(.WIDTH(8),  .DIGIT(1)) dut   (.clk(clk), .rst_n(rst_n), .bus(m));
   addsub_serial #(.WIDTH(8),  .DIGIT(2)) dut2  (.clk(clk), .rst_n(rst_n), .bus(v2));
   addsub_serial #(.WIDTH(8),  .DIGIT(4)) dut4  (.clk(clk), .rst_n(rst_n), .bus(v4));
   addsub_serial #(.WIDTH(8),  .DIGIT(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(v8));
   addsub_serial #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(v16));

   localparam int VW [5] = '{8, 8, 8, 8, 16};
   localparam int VN [5] = '{8, 4, 2, 1, 4};

   logic [4:0]  x_done, x_carry, x_ovf, x_zero;
   logic [15:0] x_sum [5];
   assign x_done  = {v16.done, v8.done, v4.done, v2.done, m.done};
   assign x_carry = {v16.carry, v8.carry, v4.carry, v2.carry, m.carry};
   assign x_ovf   = {v16.overflow, v8.overflow, v4.overflow, v2.overflow, m.overflow};
   assign x_zero  = {v16.zero, v8.zero, v4.zero, v2.zero, m.zero};
   assign x_sum[0] = {8'h00, m.sum};
   assign x_sum[1] = {8'h00, v2.sum};
   assign x_sum[2] = {8'h00, v4.sum};
   assign x_sum[3] = {8'h00, v8.sum};
   assign x_sum[4] = v16.sum;

   // Reference model: returns {zero, overflow, carry, sum[15:0]} for a w-bit operation
   function automatic logic [18:0] ref_op(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input logic md);
      logic [16:0] mask, aa, bb, full, s;
      logic        c, v;
      mask = (17'h1 << w) - 17'h1;
      aa   = {1'b0, a} & mask;
      bb   = {1'b0, (md ? ~b : b)} & mask;
      full = aa + bb + {16'h0, md};
      c    = full[w];
      s    = full & mask;
      v    = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
`ifdef ADDSUB_SAT_EN
      if (v) s = s[w-1] ? (mask >> 1) : (17'h1 << (w - 1));
`endif
      return {(s == 17'h0), v, c, s[15:0]};
   endfunction

   task automatic start_main(input logic [7:0] a, input logic [7:0] b, input logic md);
      m.a = a; m.b = b; m.mode = md; m.start = 1'b1;
      @(posedge clk); #1;
      m.start = 1'b0;
   endtask

   // Cycles from the start edge (counted as 1) to done; 0 means it never came
   task automatic wait_done_main(output int lat);
      lat = 0;
      for (int c = 2; c <= 40; c++) begin
         @(posedge clk); #1;
         if (m.done) begin
            lat = c;
            break;
         end
      end
   endtask

   task automatic test_reset();
      m.start = 1'b0; m.mode = MODE_ADD; m.a = '0; m.b = '0;
      #2 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (m.busy !== 1'b0)     begin bad++; $display("FAIL reset_busy: got %b want 0", m.busy); end
      total++; if (m.done !== 1'b0)     begin bad++; $display("FAIL reset_done: got %b want 0", m.done); end
      total++; if (m.sum !== 8'h00)     begin bad++; $display("FAIL reset_sum: got %h want 00", m.sum); end
      total++; if (m.carry !== 1'b0)    begin bad++; $display("FAIL reset_carry: got %b want 0", m.carry); end
      total++; if (m.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", m.overflow); end
      total++; if (m.zero !== 1'b0)     begin bad++; $display("FAIL reset_zero: got %b want 0", m.zero); end
      rst_n = 1'b1;
      @(posedge clk); #1;
      $display("reset: busy=%b done=%b sum=%h", m.busy, m.done, m.sum);
   endtask

   typedef struct {
      logic [7:0] a, b;
      logic       md;
      logic [7:0] s;
      logic       c, v, z;
   } vec_t;

   task automatic test_directed();
      vec_t vecs [5];
      int   lat;
      vecs[0] = '{8'h0A, 8'h0C, MODE_ADD, 8'h16, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'h0A, 8'h0C, MODE_SUB, 8'hFE, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{8'hFF, 8'h01, MODE_ADD, 8'h00, 1'b1, 1'b0, 1'b1};
`ifdef ADDSUB_SAT_EN
      vecs[3] = '{8'h7F, 8'h01, MODE_ADD, 8'h7F, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{8'h80, 8'h01, MODE_SUB, 8'h80, 1'b1, 1'b1, 1'b0};
`else
      vecs[3] = '{8'h7F, 8'h01, MODE_ADD, 8'h80, 1'b0, 1'b1, 1'b0};
      vecs[4] = '{8'h80, 8'h01, MODE_SUB, 8'h7F, 1'b1, 1'b1, 1'b0};
`endif
      for (int i = 0; i < 5; i++) begin
         start_main(vecs[i].a, vecs[i].b, vecs[i].md);
         wait_done_main(lat);
         $display("op %0d: a=%h b=%h mode=%b -> sum=%h c=%b v=%b z=%b lat=%0d",
                  i, vecs[i].a, vecs[i].b, vecs[i].md, m.sum, m.carry, m.overflow, m.zero, lat);
         total++; if (lat != 9)                   begin bad++; $display("FAIL dir%0d_latency: got %0d want 9", i, lat); end
         total++; if (m.sum !== vecs[i].s)        begin bad++; $display("FAIL dir%0d_sum: got %h want %h", i, m.sum, vecs[i].s); end
         total++; if (m.carry !== vecs[i].c)      begin bad++; $display("FAIL dir%0d_carry: got %b want %b", i, m.carry, vecs[i].c); end
         total++; if (m.overflow !== vecs[i].v)   begin bad++; $display("FAIL dir%0d_ovf: got %b want %b", i, m.overflow, vecs[i].v); end
         total++; if (m.zero !== vecs[i].z)       begin bad++; $display("FAIL dir%0d_zero: got %b want %b", i, m.zero, vecs[i].z); end
         total++; if (m.busy !== 1'b0)            begin bad++; $display("FAIL dir%0d_busy_at_done: got %b want 0", i, m.busy); end
         @(posedge clk); #1;
         total++; if (m.done !== 1'b0)            begin bad++; $display("FAIL dir%0d_done_pulse: got %b want 0", i, m.done); end
         total++; if (m.sum !== vecs[i].s)        begin bad++; $display("FAIL dir%0d_sum_hold: got %h want %h", i, m.sum, vecs[i].s); end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] oa [3] = '{8'h01, 8'h10, 8'h33};
      logic [7:0] ob [3] = '{8'h02, 8'h20, 8'h11};
      logic       om [3] = '{MODE_ADD, MODE_ADD, MODE_SUB};
      logic [7:0] es [3] = '{8'h03, 8'h30, 8'h22};
      int k = 0, prev = 0;
      m.a = oa[0]; m.b = ob[0]; m.mode = om[0]; m.start = 1'b1;
      for (int c = 1; c <= 60 && k < 3; c++) begin
         @(posedge clk); #1;
         if (c == prev + 1) begin
            if (k < 2) begin
               m.a = oa[k+1]; m.b = ob[k+1]; m.mode = om[k+1];
            end else begin
               m.start = 1'b0;
            end
         end
         if (m.done) begin
            $display("b2b %0d: sum=%h at cycle %0d", k, m.sum, c);
            total++; if (m.sum !== es[k])  begin bad++; $display("FAIL b2b%0d_sum: got %h want %h", k, m.sum, es[k]); end
            total++; if (c - prev != 9)    begin bad++; $display("FAIL b2b%0d_spacing: got %0d want 9", k, c - prev); end
            prev = c;
            k++;
         end
      end
      m.start = 1'b0;
      total++; if (k != 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", k); end
      repeat (2) @(posedge clk); #1;
   endtask

   task automatic test_start_mid_run();
      int lat = 0;
      start_main(8'h05, 8'h03, MODE_ADD);
      m.start = 1'b1; m.a = 8'hFF; m.b = 8'hFF; m.mode = MODE_SUB;
      total++; if (m.busy !== 1'b1) begin bad++; $display("FAIL midrun_busy: got %b want 1", m.busy); end
      @(posedge clk); #1; m.start = 1'b0;
      @(posedge clk); #1; m.start = 1'b1;
      @(posedge clk); #1; m.start = 1'b0;
      for (int c = 5; c <= 40; c++) begin
         @(posedge clk); #1;
         if (m.done) begin
            lat = c;
            break;
         end
      end
      $display("midrun: sum=%h c=%b lat=%0d", m.sum, m.carry, lat);
      total++; if (lat != 9)         begin bad++; $display("FAIL midrun_latency: got %0d want 9", lat); end
      total++; if (m.sum !== 8'h08)  begin bad++; $display("FAIL midrun_sum: got %h want 08", m.sum); end
      total++; if (m.carry !== 1'b0) begin bad++; $display("FAIL midrun_carry: got %b want 0", m.carry); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_run();
      int lat;
      start_main(8'hFF, 8'h02, MODE_ADD);
      wait_done_main(lat);
      start_main(8'h21, 8'h12, MODE_ADD);
      repeat (3) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      $display("reset mid-run: busy=%b done=%b sum=%h c=%b", m.busy, m.done, m.sum, m.carry);
      total++; if (m.busy !== 1'b0)     begin bad++; $display("FAIL rstrun_busy: got %b want 0", m.busy); end
      total++; if (m.done !== 1'b0)     begin bad++; $display("FAIL rstrun_done: got %b want 0", m.done); end
      total++; if (m.sum !== 8'h00)     begin bad++; $display("FAIL rstrun_sum: got %h want 00", m.sum); end
      total++; if (m.carry !== 1'b0)    begin bad++; $display("FAIL rstrun_carry: got %b want 0", m.carry); end
      total++; if (m.overflow !== 1'b0) begin bad++; $display("FAIL rstrun_ovf: got %b want 0", m.overflow); end
      total++; if (m.zero !== 1'b0)     begin bad++; $display("FAIL rstrun_zero: got %b want 0", m.zero); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      start_main(8'h21, 8'h12, MODE_ADD);
      wait_done_main(lat);
      $display("after reset: sum=%h lat=%0d", m.sum, lat);
      total++; if (lat != 9)        begin bad++; $display("FAIL rstrun_next_latency: got %0d want 9", lat); end
      total++; if (m.sum !== 8'h33) begin bad++; $display("FAIL rstrun_next_sum: got %h want 33", m.sum); end
      @(posedge clk); #1;
   endtask

   task automatic test_digit_variants();
      logic [15:0] va [6] = '{16'h1234, 16'h80F0, 16'hFFFF, 16'h7FFF, 16'h0000, 16'h5A3C};
      logic [15:0] vb [6] = '{16'h0FED, 16'h7F10, 16'h0001, 16'h0001, 16'h0001, 16'h5A3C};
      logic        vm [6] = '{MODE_ADD, MODE_SUB, MODE_ADD, MODE_ADD, MODE_SUB, MODE_SUB};
      int          lat [5];
      logic [15:0] gs [5];
      logic        gc [5], gv [5], gz [5];
      logic [18:0] e;
      for (int t = 0; t < 6; t++) begin
         v_a = va[t]; v_b = vb[t]; v_mode = vm[t]; v_start = 1'b1;
         m.a = va[t][7:0]; m.b = vb[t][7:0]; m.mode = vm[t]; m.start = 1'b1;
         for (int i = 0; i < 5; i++) lat[i] = 0;
         for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin v_start = 1'b0; m.start = 1'b0; end
            for (int i = 0; i < 5; i++) begin
               if (x_done[i] && lat[i] == 0) begin
                  lat[i] = c; gs[i] = x_sum[i]; gc[i] = x_carry[i]; gv[i] = x_ovf[i]; gz[i] = x_zero[i];
               end
            end
         end
         for (int i = 0; i < 5; i++) begin
            e = ref_op(VW[i], va[t], vb[t], vm[t]);
            $display("var t%0d w%0d d%0d: sum=%h c=%b v=%b z=%b lat=%0d", t, VW[i], VW[i] / VN[i],
                     gs[i], gc[i], gv[i], gz[i], lat[i]);
            total++; if (lat[i] != VN[i] + 1) begin bad++; $display("FAIL var%0d_%0d_latency: got %0d want %0d", t, i, lat[i], VN[i] + 1); end
            total++; if (gs[i] !== e[15:0])   begin bad++; $display("FAIL var%0d_%0d_sum: got %h want %h", t, i, gs[i], e[15:0]); end
            total++; if (gc[i] !== e[16])     begin bad++; $display("FAIL var%0d_%0d_carry: got %b want %b", t, i, gc[i], e[16]); end
            total++; if (gv[i] !== e[17])     begin bad++; $display("FAIL var%0d_%0d_ovf: got %b want %b", t, i, gv[i], e[17]); end
            total++; if (gz[i] !== e[18])     begin bad++; $display("FAIL var%0d_%0d_zero: got %b want %b", t, i, gz[i], e[18]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_back_to_back();
      test_start_mid_run();
      test_reset_mid_run();
      test_digit_variants();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
